// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: valid/ready word load, one bit per clock, back-to-back frames.
// Optional PARITY_EN macro appends a parity bit (sense set by ODD_PARITY) after each word.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic          IDLE_BIT = (IDLE_LEVEL != 0);

  if (WIDTH < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_params
    $error("piso_serializer: WIDTH must be >= 2 and ODD_PARITY must be 0 or 1");
  end

`ifdef PARITY_EN
  localparam logic ODD_BIT = (ODD_PARITY != 0);
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_q, serial_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  // last_bit marks the cycle the final frame bit is on serial_out
`ifdef PARITY_EN
  assign last_bit = (state_q == PAR);
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`endif

  assign load_ready = ~reset & ((state_q == IDLE) | last_bit);
  assign accept     = load_valid & load_ready;
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;
  assign bit_valid  = valid_q;
  assign frame_done = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    serial_d = IDLE_BIT;
    valid_d  = 1'b0;
    done_d   = 1'b0;
`ifdef PARITY_EN
    par_d    = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      valid_d = 1'b1;
      // The first bit goes straight to serial_out, so the register holds the word pre-shifted by one
      if (MSB_FIRST != 0) begin
        serial_d = data_in[WIDTH-1];
        shreg_d  = {data_in[WIDTH-2:0], 1'b0};
      end else begin
        serial_d = data_in[0];
        shreg_d  = {1'b0, data_in[WIDTH-1:1]};
      end
`ifdef PARITY_EN
      par_d = (^data_in) ^ ODD_BIT;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
`ifdef PARITY_EN
            state_d  = PAR;
            serial_d = par_q;
            valid_d  = 1'b1;
            done_d   = 1'b1;
`else
            state_d  = IDLE;
`endif
          end else begin
            cnt_d   = cnt_q + CW'(1);
            valid_d = 1'b1;
            if (MSB_FIRST != 0) begin
              serial_d = shreg_q[WIDTH-1];
              shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              serial_d = shreg_q[0];
              shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
            end
`ifndef PARITY_EN
            done_d = (cnt_q == PRE_LAST_IDX);
`endif
          end
        end
`ifdef PARITY_EN
        PAR:     state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      serial_q <= IDLE_BIT;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/even and an LSB-first/odd instance checked
// every cycle against a frame-list model, plus hand-computed stream expectations.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FL = W + 1;
  localparam logic [31:0] EXP_T1    = 32'h1AB;    // D5 + even parity 1
  localparam logic [31:0] EXP_T1_BV = 32'h1FF;
  localparam logic [31:0] EXP_T2    = 32'h1A0;    // 0B lsb-first + odd parity 0
  localparam logic [31:0] EXP_T3    = 32'h343FE;  // D0+1, FF+0
  localparam logic [31:0] EXP_T3_RD = 32'h20100;
  localparam logic [31:0] EXP_T4    = 32'h35754;  // D5+1, AA+0
  localparam logic [31:0] EXP_T5    = 32'h12C;    // 96 + 0
  localparam logic [31:0] EXP_T6    = 32'h156;    // D5 lsb-first + odd parity 0
`else
  localparam int FL = W;
  localparam logic [31:0] EXP_T1    = 32'hD5;
  localparam logic [31:0] EXP_T1_BV = 32'hFF;
  localparam logic [31:0] EXP_T2    = 32'hD0;
  localparam logic [31:0] EXP_T3    = 32'hD0FF;
  localparam logic [31:0] EXP_T3_RD = 32'h8080;
  localparam logic [31:0] EXP_T4    = 32'hD5AA;
  localparam logic [31:0] EXP_T5    = 32'h96;
  localparam logic [31:0] EXP_T6    = 32'hAB;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din0, din1;
  logic [1:0]   lv;
  wire  [1:0]   lr, so, bv, fd, bz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(0), .ODD_PARITY(0)) u_msb (
    .clk(clk), .reset(rst), .data_in(din0), .load_valid(lv[0]), .load_ready(lr[0]),
    .serial_out(so[0]), .bit_valid(bv[0]), .frame_done(fd[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0), .ODD_PARITY(1)) u_lsb (
    .clk(clk), .reset(rst), .data_in(din1), .load_valid(lv[1]), .load_ready(lr[1]),
    .serial_out(so[1]), .bit_valid(bv[1]), .frame_done(fd[1]), .busy(bz[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: each instance holds the list of bits of its current frame and the index on the wire.
  int   pos [2] = '{-1, -1};
  logic fr  [2][W+1];
  bit   model_live = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] d;
    logic         rdy;
    for (int k = 0; k < 2; k++) begin
      d   = (k == 0) ? din0 : din1;
      rdy = !rst && (pos[k] < 0 || pos[k] == FL - 1);
      if (rst) pos[k] = -1;
      else if (lv[k] && rdy) begin
        for (int i = 0; i < W; i++) fr[k][i] = (k == 0) ? d[W-1-i] : d[i];
        fr[k][W] = (^d) ^ (k == 1);
        pos[k]   = 0;
      end else if (pos[k] >= 0) begin
        pos[k] = (pos[k] == FL - 1) ? -1 : pos[k] + 1;
      end
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("serial_out[%0d]", k), 32'(so[k]), 32'(pos[k] >= 0 ? fr[k][pos[k]] : 1'b0));
        check($sformatf("bit_valid[%0d]", k),  32'(bv[k]), 32'(pos[k] >= 0));
        check($sformatf("frame_done[%0d]", k), 32'(fd[k]), 32'(pos[k] == FL - 1));
        check($sformatf("busy[%0d]", k),       32'(bz[k]), 32'(pos[k] >= 0));
        check($sformatf("load_ready[%0d]", k), 32'(lr[k]),
              32'(!rst && (pos[k] < 0 || pos[k] == FL - 1)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cap, fdv, bvv, rdy;
    logic [3:0]  hist;
    int          ndet, det_at;
    bit          bzall;

    rst = 1'b1; lv = '0; din0 = '0; din1 = '0;
    step(); step();
    check("reset serial_out", 32'(so[0]), 32'd0);
    check("reset bit_valid",  32'(bv[0]), 32'd0);
    check("reset busy",       32'(bz[0]), 32'd0);
    check("reset load_ready", 32'(lr[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("idle load_ready msb", 32'(lr[0]), 32'd1);
    check("idle load_ready lsb", 32'(lr[1]), 32'd1);

    // Test 1: single MSB-first frame
    din0 = 8'hD5; lv[0] = 1'b1; step(); lv[0] = 1'b0; din0 = '0;
    cap = '0; fdv = '0; bvv = '0;
    for (int c = 1; c <= FL; c++) begin
      cap = {cap[30:0], so[0]}; fdv = {fdv[30:0], fd[0]}; bvv = {bvv[30:0], bv[0]};
      step();
    end
    check("t1 stream", cap, EXP_T1);
    check("t1 frame_done", fdv, 32'd1);
    check("t1 bit_valid", bvv, EXP_T1_BV);
    check("t1 after serial_out", 32'(so[0]), 32'd0);
    check("t1 after bit_valid",  32'(bv[0]), 32'd0);
    check("t1 after busy",       32'(bz[0]), 32'd0);

    // Test 2: LSB-first frame into a 1101 detector
    din1 = 8'h0B; lv[1] = 1'b1; step(); lv[1] = 1'b0;
    cap = '0; hist = '0; ndet = 0; det_at = 0;
    for (int c = 1; c <= FL; c++) begin
      cap  = {cap[30:0], so[1]};
      hist = {hist[2:0], so[1]};
      if (bv[1] && hist == 4'b1101) begin ndet++; det_at = c; end
      step();
    end
    check("t2 stream", cap, EXP_T2);
    check("t2 detect count", 32'(ndet), 32'd1);
    check("t2 detect cycle", 32'(det_at), 32'd4);
    step();

    // Test 3: back-to-back frames with load_valid held
    din0 = 8'hD0; lv[0] = 1'b1;
    cap = '0; rdy = '0; bzall = 1'b1;
    for (int c = 0; c <= 2 * FL; c++) begin
      if (c < 2 * FL) rdy = {rdy[30:0], lr[0]};
      if (c >= 1) begin cap = {cap[30:0], so[0]}; bzall &= bz[0]; end
      if (c == FL) din0 = 8'hFF;
      step();
      if (c == FL) lv[0] = 1'b0;
    end
    check("t3 stream", cap, EXP_T3);
    check("t3 load_ready", rdy, EXP_T3_RD);
    check("t3 busy held", 32'(bzall), 32'd1);
    step();

    // Test 4: backpressure with data wiggling before acceptance
    din0 = 8'hD5; lv[0] = 1'b1; step(); lv[0] = 1'b0;
    cap = '0; rdy = '0;
    for (int c = 1; c <= 2 * FL; c++) begin
      if (c == 3) lv[0] = 1'b1;
      if (c >= 3 && c < FL) din0 = 8'(8'h11 * c);
      if (c == FL) din0 = 8'hAA;
      if (c >= 3 && c <= FL) rdy = {rdy[30:0], lr[0]};
      cap = {cap[30:0], so[0]};
      step();
      if (c == FL) lv[0] = 1'b0;
    end
    check("t4 stream", cap, EXP_T4);
    check("t4 load_ready", rdy, 32'd1);
    step();

    // Test 5: reset mid-frame, load during reset ignored
    din0 = 8'hD5; lv[0] = 1'b1; step(); lv[0] = 1'b0;
    step(); step(); step();
    rst = 1'b1; lv[0] = 1'b1; din0 = 8'h3C;
    #1;
    check("t5 load_ready in reset", 32'(lr[0]), 32'd0);
    step();
    rst = 1'b0; lv[0] = 1'b0;
    check("t5 serial_out", 32'(so[0]), 32'd0);
    check("t5 bit_valid",  32'(bv[0]), 32'd0);
    check("t5 busy",       32'(bz[0]), 32'd0);
    check("t5 frame_done", 32'(fd[0]), 32'd0);
    din0 = 8'h96; lv[0] = 1'b1; step(); lv[0] = 1'b0;
    cap = '0;
    for (int c = 1; c <= FL; c++) begin
      cap = {cap[30:0], so[0]};
      step();
    end
    check("t5 stream", cap, EXP_T5);

    // Test 6: LSB-first instance with odd parity sense
    din1 = 8'hD5; lv[1] = 1'b1; step(); lv[1] = 1'b0;
    cap = '0; fdv = '0;
    for (int c = 1; c <= FL; c++) begin
      cap = {cap[30:0], so[1]}; fdv = {fdv[30:0], fd[1]};
      step();
    end
    check("t6 stream", cap, EXP_T6);
    check("t6 frame_done", fdv, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that feeds a single-bit stream into the downstream Mealy "1101" sequence detector.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock, with a bit_valid qualifier and an end-of-frame pulse.
- Supports back-to-back frames with no idle gap, so the detector sees a continuous stream.

Parameters:
WIDTH, 8, data word width in bits (legal range >= 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
IDLE_LEVEL, 0, value driven on serial_out when no bit is being sent
ODD_PARITY, 0, parity sense for the optional parity bit (0 = even, 1 = odd); has no effect unless PARITY_EN is defined

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word; upstream holds it stable while load_valid=1 and not yet accepted
load_valid  input  1  upstream has a word to send
load_ready  output  1  serializer can accept a word this cycle
serial_out  output  1  registered serial bit to the sequence detector
bit_valid  output  1  registered; 1 when serial_out carries a frame bit
frame_done  output  1  registered one-cycle pulse coincident with the last bit of a frame
busy  output  1  1 while a frame is being shifted out (state != IDLE)

Behaviour:
- Reset values: serial_out=IDLE_LEVEL, bit_valid=0, frame_done=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Reset has priority over everything, including a load in the same cycle.
- Reset asserted mid-frame drops the frame with no frame_done.
- FSM states: IDLE, SHIFT (plus PAR with PARITY_EN).
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in the cycle the final frame bit is on serial_out (last data bit, or parity bit when enabled).
  - 0 otherwise, and 0 while reset=1.
- Accept = load_valid & load_ready at a rising edge. On accept:
  - data_in is captured into the shift register.
  - The bit counter is cleared.
  - State moves to SHIFT.
- Latency: the first bit of an accepted word appears on serial_out, with bit_valid=1, in the cycle immediately after the accepting edge. Bits follow on consecutive cycles with no gaps.
- Bit order:
  - MSB_FIRST=1: data[WIDTH-1] first, down to data[0].
  - MSB_FIRST=0: data[0] first, up to data[WIDTH-1].
- Bit counter: clog2(WIDTH) bits wide; counts 0..WIDTH-1; no wrap beyond WIDTH-1.
- frame_done=1 in the same cycle as the last bit. At the following edge:
  - If a new word is accepted, stay in SHIFT; the next frame's first bit follows with no gap.
  - Otherwise go to IDLE; serial_out returns to IDLE_LEVEL and bit_valid=0.
- load_valid while load_ready=0 is ignored. There is no internal buffering; upstream must hold.
- data_in changes while not accepted have no effect.
- busy=1 in SHIFT/PAR. During a back-to-back handoff, busy stays 1 continuously.

Optional Feature:
Macro: PARITY_EN
- Defined:
  - After the WIDTH data bits, one extra PAR cycle outputs the parity bit with bit_valid=1.
  - Parity bit = XOR of the accepted word, inverted when ODD_PARITY=1.
  - frame_done and the back-to-back load_ready window move to the parity-bit cycle.
  - Frame length is WIDTH+1 cycles.
- Not defined:
  - No PAR state and no parity logic; ODD_PARITY is unused.
  - frame_done is on the last data bit; frame length is WIDTH cycles.

Test Plan:
1. Single frame (WIDTH=8, MSB_FIRST=1): load 8'hD5 accepted at edge 0 -> serial_out = 1,1,0,1,0,1,0,1 in cycles 1..8; bit_valid=1 for cycles 1..8; frame_done=1 only in cycle 8; cycle 9: serial_out=0, bit_valid=0, busy=0.
2. LSB-first (MSB_FIRST=0): load 8'h0B -> serial_out = 1,1,0,1,0,0,0,0; this stream fed to the downstream detector produces exactly one out=1 pulse, in cycle 4.
3. Back-to-back: load_valid held high with 8'hD0, then 8'hFF presented in the frame_done cycle -> 16 contiguous valid bits 11010000_11111111; busy never drops; load_ready=1 only in cycles 0 and 8.
4. Backpressure: assert load_valid with 8'hAA at cycle 3 of an active frame -> not accepted until the last-bit cycle (cycle 8); the word is sent starting cycle 9, and data_in wiggles before acceptance are not reflected.
5. Reset mid-frame: reset=1 during cycle 4 of 8'hD5 -> next cycle: serial_out=IDLE_LEVEL, bit_valid=0, busy=0, no frame_done; a load in the reset cycle is ignored; a new load after reset is sent correctly.
6. PARITY_EN, ODD_PARITY=0: load 8'hD5 (five ones) -> 9 bits 1,1,0,1,0,1,0,1,1; frame_done on bit 9. With ODD_PARITY=1 the ninth bit is 0.
